inventory_report_tx: RTL

//  Downstream UART reporter for the medicine inventory counter. On a start

---
 rtl/inventory_report_tx_if.sv | 22 ++
 rtl/inventory_report_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/inventory_report_tx_if.sv
// Report-line request/status bundle between the inventory counter and the UART reporter.
interface inventory_report_tx_if;
    logic       start;
    logic [9:0] slot_sel;
    logic [3:0] slot_cnt;
    logic [7:0] total;
    logic       busy;
    logic       done;
    logic       txd;

    // Requester side: issues start and the report fields, observes status and the serial line.
    modport master (
        output start, slot_sel, slot_cnt, total,
        input  busy, done, txd
    );

    // Reporter side: consumes the request, drives status and the serial line.
    modport slave (
        input  start, slot_sel, slot_cnt, total,
        output busy, done, txd
    );
endinterface

// File: rtl/inventory_report_tx.sv
// UART reporter: latches slot/count/total on start and sends
// "S<slot>=<cnt> T<tens><ones>\r\n" as 8N1, LSB first.
module inventory_report_tx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic                 clk,
    input  logic                 rst,
    inventory_report_tx_if.slave bus
);

    localparam int unsigned BAUD_W    = 16;
    localparam int unsigned BYTE_W    = 4;
    localparam int unsigned BIT_W     = 3;
    localparam int unsigned N_BYTES   = 10;
    localparam int unsigned N_SLOTS   = 10;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N_BYTES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);

    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_QUERY = 8'h3F;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e                   state_q, state_d;
    logic [BAUD_W-1:0]        baud_q, baud_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]        byte_q, byte_d;
    logic [N_BYTES-1:0][7:0]  line_q, line_d;
    logic                     txd_q, txd_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [N_BYTES-1:0][7:0]  enc_line;
    logic [7:0]               slot_char;
    logic [7:0]               cnt_char;
    logic [7:0]               tens_char;
    logic [7:0]               ones_char;
    logic [7:0]               tens_v;
    logic [7:0]               ones_v;
    logic [7:0]               cur_byte;
    logic [BIT_W-1:0]         next_bit;
    logic                     bit_end;

    // Encode the live inputs into the ASCII line; captured only on accept.
    always_comb begin
        slot_char = CH_DASH;
        if ($countones(bus.slot_sel) == 1) begin
            for (int k = 0; k < int'(N_SLOTS); k++) begin
                if (bus.slot_sel[k]) begin
                    slot_char = CH_ZERO + 8'(k);
                end
            end
        end

        cnt_char = (bus.slot_cnt > 4'd9) ? CH_QUERY : (CH_ZERO + {4'h0, bus.slot_cnt});

        tens_v    = bus.total / 8'd10;
        ones_v    = bus.total - (tens_v * 8'd10);
        tens_char = CH_ZERO + tens_v;
        ones_char = CH_ZERO + ones_v;
        if (bus.total > 8'd99) begin
            tens_char = CH_QUERY;
            ones_char = CH_QUERY;
        end

        enc_line = {CH_LF, CH_CR, ones_char, tens_char, CH_T, CH_SPACE,
                    cnt_char, CH_EQ, slot_char, CH_S};
    end

    assign cur_byte = line_q[byte_q];
    assign next_bit = bit_q + BIT_W'(1);
    assign bit_end  = (baud_q == BAUD_LAST);

    // Frame sequencing: next state, counters and registered line outputs.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        line_d  = line_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : (baud_q + BAUD_W'(1));
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = S_START;
                    line_d  = enc_line;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = next_bit;
                        txd_d = cur_byte[next_bit];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d = S_IDLE;
                        byte_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        txd_d   = 1'b1;
                    end else begin
                        state_d = S_START;
                        byte_d  = byte_q + BYTE_W'(1);
                        txd_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            line_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
